store_rmw_ctrl: RTL and testbench
=================================

// Module: store_rmw_ctrl
// PURPOSE
//  Write-side counterpart of the load byte/halfword extractor: performs SB/SH/SW
//  into a word-wide data memory that has no byte enables. Sub-word stores use a
//  read-modify-write (read word, merge lane, write word); SW writes directly.
//  Sits between the MEM stage and the data RAM port; stalls the pipeline via ready.
// PARAMETERS
//  AW  32  byte-address width; mem_addr carries the word address, AW-2 bits
// PORTS
//  clk           in   1      system clock, all state on rising edge
//  rst           in   1      synchronous, active-high reset
//  store_req     in   1      store request, accepted only in a cycle where ready=1
//  storetype     in   2      0=SB, 1=SH, 2=SW, 3=illegal
//  addr          in   AW     byte address of the store
//  wdata         in   32     source register value; low byte/half used for SB/SH
//  ready         out  1      controller idle, can accept store_req this cycle
//  done          out  1      one-cycle pulse: store retired (written or rejected)
//  err           out  1      valid with done: misaligned or illegal type, no write
//  mem_addr      out  AW-2   word address to RAM (addr[AW-1:2] of the latched request)
//  mem_rd_en     out  1      one-cycle read strobe
//  mem_rd_data   in   32     RAM read word
//  mem_rd_valid  in   1      mem_rd_data valid; arbitrary latency >= 1 cycle
//  mem_wr_en     out  1      one-cycle write strobe
//  mem_wr_data   out  32     merged word to write
// BEHAVIOUR
//  - clk is the only clock; rst is synchronous and active-high.
//  - Reset: state=IDLE; done=err=mem_rd_en=mem_wr_en=0; mem_addr=0; mem_wr_data=0;
//    ready=1 (ready is combinational: state==IDLE).
//  - Acceptance: store_req && ready latches storetype, addr, and wdata. While
//    ready=0, store_req is ignored; upstream holds the request until done.
//  - FSM: IDLE, READ, WAIT, WRITE, DONE.
//    IDLE->WRITE for SW (aligned); IDLE->READ for SB, SH (aligned);
//    IDLE->DONE with err=1 on: SH with addr[0]=1; SW with addr[1:0]!=0; type 3.
//    READ: mem_rd_en=1 for exactly one cycle, then go to WAIT.
//    WAIT: stay until mem_rd_valid=1, then capture the merged word and go to WRITE.
//    WRITE: mem_wr_en=1 for one cycle with mem_wr_data, then go to DONE.
//    DONE: done=1 for one cycle, then go to IDLE.
//  - Latency (accept at cycle T): SW: wr_en at T+1, done at T+2.
//    SB/SH: rd_en at T+1; if rd_valid arrives at cycle V, wr_en at V+1 and done at V+2.
//    Error: done=err=1 at T+1, and neither strobe is asserted.
//  - Merge, little-endian lanes:
//    SB lane addr[1:0]: 00->[7:0], 01->[15:8], 10->[23:16], 11->[31:24], filled with wdata[7:0].
//    SH lane addr[1]: 0->[15:0], 1->[31:16], filled with wdata[15:0].
//    All other bits keep mem_rd_data. SW writes wdata unchanged.
//  - mem_addr is stable from T+1 through the write cycle.
//  - mem_rd_valid outside WAIT is ignored. A rd_valid in the same cycle as the
//    READ strobe is ignored; at least 1 cycle of latency is required.
//  - rst in any state aborts at once: IDLE next cycle; no write issued; no done pulse.
//  - A new request may be accepted in the cycle after done (IDLE). There is no
//    back-to-back acceptance in the DONE cycle.
// STRUCTURE
//  - Shared package/header: STORE_SB/SH/SW codes (2'd0/1/2) and state encodings,
//    kept alongside the LOAD_* codes.
//  - Sub-module store_merge: combinational (old_word, wdata, storetype, addr_low) -> new_word.
//    Instantiated once; FSM and registers stay in store_rmw_ctrl.
// TESTING
//  1) SW: addr=0x100, wdata=0xDEADBEEF -> no rd_en; wr_en at T+1 with
//     mem_addr=0x40, data 0xDEADBEEF; done at T+2, err=0.
//  2) SB, all 4 lanes: RAM word 0x11223344, wdata=0xAB, addr low 01, rd_valid
//     latency 3 -> write 0x1122AB44; lanes 00/10/11 give 0x112233AB,
//     0x11AB3344, 0xAB223344.
//  3) SH: addr low 10, wdata=0x5566CAFE, RAM 0x11223344 -> write 0xCAFE3344;
//     addr low 00 -> 0x1122CAFE.
//  4) Misaligned: SH at addr 0x101, SW at 0x102, type 3 -> done=err=1 at T+1;
//     rd_en and wr_en never asserted.
//  5) Reset in WAIT: assert rst, then drive rd_valid -> no wr_en, no done;
//     ready=1 next cycle. A following SB completes correctly.
//  6) Stall: store_req held high through a slow read (latency 10) -> exactly one
//     write. Second request accepted only after done; spurious rd_valid in IDLE ignored.

Source files
------------

// File: rtl/store_rmw_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_rmw_ctrl_pkg
//  Description : Shared load/store type codes, store-controller state
//                encodings and the store alignment check.
//  Revision    : 1.0 - initial release
// ============================================================================
package store_rmw_ctrl_pkg;

    // Store type codes, as carried on storetype_i
    localparam logic [1:0] STORE_SB  = 2'd0;
    localparam logic [1:0] STORE_SH  = 2'd1;
    localparam logic [1:0] STORE_SW  = 2'd2;
    localparam logic [1:0] STORE_ILL = 2'd3;

    // Load type codes used by the matching load extractor
    localparam logic [2:0] LOAD_LB  = 3'd0;
    localparam logic [2:0] LOAD_LH  = 3'd1;
    localparam logic [2:0] LOAD_LW  = 3'd2;
    localparam logic [2:0] LOAD_LBU = 3'd3;
    localparam logic [2:0] LOAD_LHU = 3'd4;

    // Store controller state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // High when the store cannot be performed: misaligned or illegal type
    function automatic logic store_is_bad(input logic [1:0] st, input logic [1:0] lo);
        logic bad;
        case (st)
            STORE_SB: bad = 1'b0;
            STORE_SH: bad = lo[0];
            STORE_SW: bad = (lo != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_merge.sv
`default_nettype none
// ============================================================================
//  Module      : store_merge
//  Description : Combinational lane merge for sub-word stores. Inserts the
//                low byte/half of wdata into the little-endian lane selected
//                by the low address bits; other bits keep the old word.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_merge
    import store_rmw_ctrl_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  storetype_i,
    input  logic [1:0]  addr_low_i,
    output logic [31:0] new_word_o
);

    // Replace only the addressed lane; SW passes wdata through whole
    always_comb begin
        new_word_o = old_word_i;
        case (storetype_i)
            STORE_SB: begin
                case (addr_low_i)
                    2'b00:   new_word_o[7:0]   = wdata_i[7:0];
                    2'b01:   new_word_o[15:8]  = wdata_i[7:0];
                    2'b10:   new_word_o[23:16] = wdata_i[7:0];
                    default: new_word_o[31:24] = wdata_i[7:0];
                endcase
            end
            STORE_SH: begin
                if (addr_low_i[1]) new_word_o[31:16] = wdata_i[15:0];
                else               new_word_o[15:0]  = wdata_i[15:0];
            end
            STORE_SW: new_word_o = wdata_i;
            default:  new_word_o = old_word_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/store_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : store_rmw_ctrl
//  Description : SB/SH/SW store controller for a word-wide RAM without byte
//                enables. Sub-word stores do read-modify-write, SW writes
//                directly, misaligned/illegal stores retire with err.
//                ready_o stalls the pipeline while a store is in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_rmw_ctrl
    import store_rmw_ctrl_pkg::*;
#(
    parameter int AW = 32
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          store_req_i,
    input  logic [1:0]    storetype_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic          ready_o,
    output logic          done_o,
    output logic          err_o,
    output logic [AW-3:0] mem_addr_o,
    output logic          mem_rd_en_o,
    input  logic [31:0]   mem_rd_data_i,
    input  logic          mem_rd_valid_i,
    output logic          mem_wr_en_o,
    output logic [31:0]   mem_wr_data_o
);

    logic [2:0]    state_q, state_d;
    logic [1:0]    type_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   wr_data_q;
    logic          err_q;
    logic          accept;
    logic [31:0]   merged_word;

    assign accept = store_req_i && (state_q == ST_IDLE);

    store_merge u_merge (
        .old_word_i  (mem_rd_data_i),
        .wdata_i     (wdata_q),
        .storetype_i (type_q),
        .addr_low_i  (addr_q[1:0]),
        .new_word_o  (merged_word)
    );

    // State register; reset aborts any store in flight
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Request latch and write-word capture (wdata for SW, merge for SB/SH)
    always_ff @(posedge clk) begin
        if (rst) begin
            type_q    <= STORE_SB;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else if (accept) begin
            type_q    <= storetype_i;
            addr_q    <= addr_i;
            wdata_q   <= wdata_i;
            wr_data_q <= wdata_i;
            err_q     <= store_is_bad(storetype_i, addr_i[1:0]);
        end else if (state_q == ST_WAIT && mem_rd_valid_i) begin
            wr_data_q <= merged_word;
        end
    end

    // Next-state decode; rd_valid only matters while waiting for it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (store_req_i) begin
                    if (store_is_bad(storetype_i, addr_i[1:0])) state_d = ST_DONE;
                    else if (storetype_i == STORE_SW)           state_d = ST_WRITE;
                    else                                         state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT:  if (mem_rd_valid_i) state_d = ST_WRITE;
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobes and handshake decoded from the current state
    always_comb begin
        ready_o     = (state_q == ST_IDLE);
        mem_rd_en_o = (state_q == ST_READ);
        mem_wr_en_o = (state_q == ST_WRITE);
        done_o      = (state_q == ST_DONE);
        err_o       = (state_q == ST_DONE) && err_q;
    end

    assign mem_addr_o    = addr_q[AW-1:2];
    assign mem_wr_data_o = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_store_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_rmw_ctrl
//  Description : Directed self-checking bench for store_rmw_ctrl with a
//                cycle-scheduled RAM read response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_rmw_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        store_req;
    logic [1:0]  storetype;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [29:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data;
    logic        mem_rd_valid;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;

    int n_cmp = 0;
    int n_mis = 0;
    int wr_pulses = 0;
    int w0;

    always #5 clk = ~clk;

    store_rmw_ctrl #(.AW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .store_req_i    (store_req),
        .storetype_i    (storetype),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .ready_o        (ready),
        .done_o         (done),
        .err_o          (err),
        .mem_addr_o     (mem_addr),
        .mem_rd_en_o    (mem_rd_en),
        .mem_rd_data_i  (mem_rd_data),
        .mem_rd_valid_i (mem_rd_valid),
        .mem_wr_en_o    (mem_wr_en),
        .mem_wr_data_o  (mem_wr_data)
    );

    // Count every write strobe seen by the RAM
    always @(posedge clk) if (mem_wr_en === 1'b1) wr_pulses++;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One store from acceptance to the return of ready, checking each cycle.
    // lat is the read latency in cycles after the rd_en cycle.
    task automatic run_store(input logic [1:0] ty, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] ram,
                             input int lat, input logic [31:0] exp_data,
                             input logic exp_err, input logic hold);
        check_val("ready_before", {31'd0, ready}, 32'd1);
        storetype = ty; addr = a; wdata = wd; store_req = 1'b1;
        tick;
        if (!hold) store_req = 1'b0;
        if (exp_err) begin
            check_val("err_done", {31'd0, done}, 32'd1);
            check_val("err_flag", {31'd0, err}, 32'd1);
            check_val("err_no_rd", {31'd0, mem_rd_en}, 32'd0);
            check_val("err_no_wr", {31'd0, mem_wr_en}, 32'd0);
            store_req = 1'b0;
            tick;
        end else if (ty == 2'd2) begin
            check_val("sw_no_rd", {31'd0, mem_rd_en}, 32'd0);
            check_val("sw_wr_en", {31'd0, mem_wr_en}, 32'd1);
            check_val("sw_addr", {2'b00, mem_addr}, {2'b00, a[31:2]});
            check_val("sw_data", mem_wr_data, exp_data);
            tick;
            check_val("sw_done", {31'd0, done}, 32'd1);
            check_val("sw_err", {31'd0, err}, 32'd0);
            check_val("sw_wr_off", {31'd0, mem_wr_en}, 32'd0);
            store_req = 1'b0;
            tick;
        end else begin
            check_val("rmw_rd_en", {31'd0, mem_rd_en}, 32'd1);
            check_val("rmw_no_wr", {31'd0, mem_wr_en}, 32'd0);
            check_val("rmw_addr_rd", {2'b00, mem_addr}, {2'b00, a[31:2]});
            // Junk on the data bus until the scheduled valid cycle
            mem_rd_data = 32'hFFFF_FFFF;
            for (int i = 1; i <= lat; i++) begin
                tick;
                check_val("wait_no_rd", {31'd0, mem_rd_en}, 32'd0);
                check_val("wait_no_wr", {31'd0, mem_wr_en}, 32'd0);
                check_val("wait_ready", {31'd0, ready}, 32'd0);
                if (i == lat) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = ram;
                end
            end
            tick;
            mem_rd_valid = 1'b0;
            mem_rd_data  = 32'h0;
            check_val("rmw_wr_en", {31'd0, mem_wr_en}, 32'd1);
            check_val("rmw_data", mem_wr_data, exp_data);
            check_val("rmw_addr_wr", {2'b00, mem_addr}, {2'b00, a[31:2]});
            tick;
            check_val("rmw_done", {31'd0, done}, 32'd1);
            check_val("rmw_err", {31'd0, err}, 32'd0);
            check_val("rmw_ready_done", {31'd0, ready}, 32'd0);
            store_req = 1'b0;
            tick;
        end
        check_val("ready_after", {31'd0, ready}, 32'd1);
        check_val("done_after", {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; store_req = 1'b0; storetype = 2'd0; addr = 32'h0; wdata = 32'h0;
        mem_rd_data = 32'h0; mem_rd_valid = 1'b0;
        repeat (3) tick;
        check_val("rst_ready", {31'd0, ready}, 32'd1);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);
        check_val("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check_val("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check_val("rst_addr", {2'b00, mem_addr}, 32'd0);
        check_val("rst_wdata", mem_wr_data, 32'd0);
        rst = 1'b0;
        tick;

        // SW direct write
        run_store(2'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
        // SB into each lane
        run_store(2'd0, 32'h201, 32'h000000AB, 32'h11223344, 3, 32'h1122AB44, 1'b0, 1'b0);
        run_store(2'd0, 32'h200, 32'h000000AB, 32'h11223344, 3, 32'h112233AB, 1'b0, 1'b0);
        run_store(2'd0, 32'h202, 32'h000000AB, 32'h11223344, 1, 32'h11AB3344, 1'b0, 1'b0);
        run_store(2'd0, 32'h203, 32'h000000AB, 32'h11223344, 2, 32'hAB223344, 1'b0, 1'b0);
        // SH upper and lower half
        run_store(2'd1, 32'h302, 32'h5566CAFE, 32'h11223344, 2, 32'hCAFE3344, 1'b0, 1'b0);
        run_store(2'd1, 32'h300, 32'h5566CAFE, 32'h11223344, 2, 32'h1122CAFE, 1'b0, 1'b0);
        // Rejected stores
        run_store(2'd1, 32'h101, 32'h12345678, 32'h0, 0, 32'h0, 1'b1, 1'b0);
        run_store(2'd2, 32'h102, 32'h12345678, 32'h0, 0, 32'h0, 1'b1, 1'b0);
        run_store(2'd3, 32'h104, 32'h12345678, 32'h0, 0, 32'h0, 1'b1, 1'b0);

        // Reset while waiting for read data
        w0 = wr_pulses;
        storetype = 2'd0; addr = 32'h202; wdata = 32'h77; store_req = 1'b1;
        tick;
        store_req = 1'b0;
        check_val("rw_rd_en", {31'd0, mem_rd_en}, 32'd1);
        tick;
        check_val("rw_busy", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        mem_rd_valid = 1'b1; mem_rd_data = 32'h11223344;
        check_val("rw_ready", {31'd0, ready}, 32'd1);
        check_val("rw_done0", {31'd0, done}, 32'd0);
        tick;
        mem_rd_valid = 1'b0;
        check_val("rw_no_wr", {31'd0, mem_wr_en}, 32'd0);
        check_val("rw_done1", {31'd0, done}, 32'd0);
        tick;
        check_val("rw_done2", {31'd0, done}, 32'd0);
        check_val("rw_wr_count", wr_pulses - w0, 32'd0);
        run_store(2'd0, 32'h203, 32'h000000CD, 32'h11223344, 1, 32'hCD223344, 1'b0, 1'b0);

        // Request held through a slow read
        w0 = wr_pulses;
        run_store(2'd0, 32'h201, 32'h000000AB, 32'h11223344, 10, 32'h1122AB44, 1'b0, 1'b1);
        check_val("stall_one_write", wr_pulses - w0, 32'd1);

        // Spurious read data while idle
        mem_rd_valid = 1'b1; mem_rd_data = 32'h0;
        tick;
        mem_rd_valid = 1'b0;
        check_val("idle_rv_ready", {31'd0, ready}, 32'd1);
        check_val("idle_rv_wr", {31'd0, mem_wr_en}, 32'd0);
        check_val("idle_rv_done", {31'd0, done}, 32'd0);
        run_store(2'd2, 32'h104, 32'h0BADF00D, 32'h0, 0, 32'h0BADF00D, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
